// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back arbiter.
package regfile_pkg;

    localparam int unsigned DEF_REG_COUNT = 32;
    localparam int unsigned DEF_REG_WIDTH = 32;

    // CLEAR sweeps zeros into every register; RUN arbitrates requester writes.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches upward from the pointer, modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    logic [IDX_W-1:0] w_k;
    logic             w_found;

    // First asserted request at or above the pointer wins, wrapping to 0.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_k       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_k = IDX_W'((32'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_k]) begin
                o_gnt[w_k] = 1'b1;
                o_gnt_idx  = w_k;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: zero-sweeps the register file, then grants one
// requester write per cycle round-robin, registered onto the rf_* port.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned REG_COUNT = DEF_REG_COUNT,
    parameter  int unsigned REG_WIDTH = DEF_REG_WIDTH,
    localparam int unsigned AW        = $clog2(REG_COUNT),
    localparam int unsigned IW        = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     clear_req_i,
    output logic                     clear_busy_o,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*AW-1:0]    req_addr_i,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_data_i,
    output logic [AW-1:0]            rf_addr_o,
    output logic [REG_WIDTH-1:0]     rf_data_o,
    output logic                     rf_wr_en_o,
    output logic [IW-1:0]            grant_id_o
);

    state_e                 r_state;
    logic [AW-1:0]          r_sweep_addr;
    logic [IW-1:0]          r_ptr;
    logic                   r_wr_en;
    logic [AW-1:0]          r_addr;
    logic [REG_WIDTH-1:0]   r_data;
    logic [IW-1:0]          r_gid;

    logic [NUM_REQ-1:0]     w_arb_req;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [IW-1:0]          w_gnt_idx;
    logic                   w_xfer;
    logic                   w_sweep_last;

    // Requests are masked while sweeping and in the cycle a clear is requested.
    assign w_arb_req    = (r_state == RUN && !clear_req_i) ? req_valid_i : '0;
    assign w_xfer       = |w_gnt;
    assign w_sweep_last = (r_sweep_addr == AW'(REG_COUNT - 1));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr_arbiter (
        .i_req     (w_arb_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // FSM and sweep counter; the counter stops at REG_COUNT-1 and never wraps.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= CLEAR;
            r_sweep_addr <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (w_sweep_last) begin
                        r_state      <= RUN;
                        r_sweep_addr <= '0;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req_i) begin
                        r_state      <= CLEAR;
                        r_sweep_addr <= '0;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    // Priority pointer moves past the winner only on a transfer.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Registered write port: sweep zeros, granted write, or idle (hold data).
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_gid   <= '0;
        end else if (r_state == CLEAR) begin
            r_wr_en <= 1'b1;
            r_addr  <= r_sweep_addr;
            r_data  <= '0;
        end else if (w_xfer) begin
            r_wr_en <= 1'b1;
            r_addr  <= req_addr_i[32'(w_gnt_idx) * AW +: AW];
            r_data  <= req_data_i[32'(w_gnt_idx) * REG_WIDTH +: REG_WIDTH];
            r_gid   <= w_gnt_idx;
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    assign clear_busy_o = (r_state == CLEAR);
    assign req_ready_o  = w_gnt;
    assign rf_wr_en_o   = r_wr_en;
    assign rf_addr_o    = r_addr;
    assign rf_data_o    = r_data;
    assign grant_id_o   = r_gid;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a behavioural model pushes expected register-file writes,
// a monitor pops and compares them against the DUT on the falling edge.
module tb_regfile_wb_arbiter;

    localparam int NR = 4;
    localparam int RC = 32;
    localparam int RW = 32;
    localparam int AW = 5;
    localparam int IW = 2;

    logic                clk_i = 1'b0;
    logic                reset_ni;
    logic                clear_req_i;
    logic                clear_busy_o;
    logic [NR-1:0]       req_valid_i;
    logic [NR-1:0]       req_ready_o;
    logic [NR*AW-1:0]    req_addr_i;
    logic [NR*RW-1:0]    req_data_i;
    logic [AW-1:0]       rf_addr_o;
    logic [RW-1:0]       rf_data_o;
    logic                rf_wr_en_o;
    logic [IW-1:0]       grant_id_o;

    logic [AW-1:0]       a_addr [NR];
    logic [RW-1:0]       a_data [NR];

    regfile_wb_arbiter #(
        .NUM_REQ   (NR),
        .REG_COUNT (RC),
        .REG_WIDTH (RW)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .clear_req_i  (clear_req_i),
        .clear_busy_o (clear_busy_o),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .rf_addr_o    (rf_addr_o),
        .rf_data_o    (rf_data_o),
        .rf_wr_en_o   (rf_wr_en_o),
        .grant_id_o   (grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        req_addr_i = '0;
        req_data_i = '0;
        for (int k = 0; k < NR; k++) begin
            req_addr_i[k*AW +: AW] = a_addr[k];
            req_data_i[k*RW +: RW] = a_data[k];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            sweep;
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
        int            gid;
    } exp_t;

    exp_t exp_q[$];
    bit   m_busy  = 1'b1;
    int   m_sweep = 0;
    int   m_ptr   = 0;

    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (v[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r;
        int            w;
        r = '0;
        if (reset_ni && !m_busy && !clear_req_i) begin
            w = pick(req_valid_i, m_ptr);
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        exp_t e;
        int   w;
        forever begin
            @(posedge clk_i or negedge reset_ni);
            if (!reset_ni) begin
                m_busy  = 1'b1;
                m_sweep = 0;
                m_ptr   = 0;
                exp_q.delete();
            end else if (m_busy) begin
                e.sweep = 1'b1;
                e.addr  = AW'(m_sweep);
                e.data  = '0;
                e.gid   = 0;
                exp_q.push_back(e);
                m_sweep++;
                if (m_sweep == RC) m_busy = 1'b0;
            end else if (clear_req_i) begin
                m_busy  = 1'b1;
                m_sweep = 0;
            end else begin
                w = pick(req_valid_i, m_ptr);
                if (w >= 0) begin
                    e.sweep = 1'b0;
                    e.addr  = a_addr[w];
                    e.data  = a_data[w];
                    e.gid   = w;
                    exp_q.push_back(e);
                    m_ptr = (w + 1) % NR;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [AW-1:0] last_addr;
    logic [RW-1:0] last_data;
    int            last_gid;

    initial begin
        exp_t e;
        last_addr = '0;
        last_data = '0;
        last_gid  = 0;
        forever begin
            @(negedge clk_i);
            if (!reset_ni) begin
                chk("rst_wr_en", 64'(rf_wr_en_o), 64'(0));
                chk("rst_addr", 64'(rf_addr_o), 64'(0));
                chk("rst_data", 64'(rf_data_o), 64'(0));
                chk("rst_gid", 64'(grant_id_o), 64'(0));
                chk("rst_busy", 64'(clear_busy_o), 64'(1));
                chk("rst_ready", 64'(req_ready_o), 64'(0));
                last_addr = '0;
                last_data = '0;
                last_gid  = 0;
            end else begin
                chk("ready", 64'(req_ready_o), 64'(exp_ready()));
                chk("busy", 64'(clear_busy_o), 64'(m_busy));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk(e.sweep ? "sweep_wr_en" : "wr_en", 64'(rf_wr_en_o), 64'(1));
                    chk(e.sweep ? "sweep_addr" : "addr", 64'(rf_addr_o), 64'(e.addr));
                    chk(e.sweep ? "sweep_data" : "data", 64'(rf_data_o), 64'(e.data));
                    last_addr = e.addr;
                    last_data = e.data;
                    if (!e.sweep) begin
                        chk("gid", 64'(grant_id_o), 64'(e.gid));
                        last_gid = e.gid;
                    end
                end else begin
                    chk("idle_wr_en", 64'(rf_wr_en_o), 64'(0));
                    chk("idle_addr_hold", 64'(rf_addr_o), 64'(last_addr));
                    chk("idle_data_hold", 64'(rf_data_o), 64'(last_data));
                    chk("idle_gid_hold", 64'(grant_id_o), 64'(last_gid));
                end
            end
        end
    end

    // ---------------- requester driver ----------------
    // mode: 0 random, 1 all valid, 2 no new requests, 3 only req 2 (addr 5),
    //       4 only req 1
    int mode      = 2;
    bit clr_force = 1'b0;

    initial begin
        logic [NR-1:0] rdy;
        req_valid_i = '0;
        clear_req_i = 1'b0;
        for (int k = 0; k < NR; k++) begin
            a_addr[k] = '0;
            a_data[k] = '0;
        end
        forever begin
            @(negedge clk_i);
            rdy = req_ready_o;
            @(posedge clk_i);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (req_valid_i[k] && rdy[k]) req_valid_i[k] = 1'b0;
                if (!req_valid_i[k]) begin
                    if ((mode == 0 && $urandom_range(0, 2) == 0) || mode == 1 ||
                        (mode == 4 && k == 1)) begin
                        req_valid_i[k] = 1'b1;
                        a_addr[k]      = AW'($urandom_range(0, RC - 1));
                        a_data[k]      = $urandom;
                    end else if (mode == 3 && k == 2) begin
                        req_valid_i[k] = 1'b1;
                        a_addr[k]      = AW'(5);
                        a_data[k]      = 32'hDEAD_BEEF;
                    end
                end
            end
            clear_req_i = clr_force || (mode == 0 && $urandom_range(0, 59) == 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        reset_ni = 1'b0;
        cycles(3);
        #1 reset_ni = 1'b1;

        // Power-up sweep, then single requester 2.
        cycles(36);
        mode = 3;
        cycles(4);
        mode = 2;
        cycles(4);

        // All requesters valid: strict rotation.
        mode = 1;
        cycles(12);
        mode = 2;
        cycles(6);

        // Clear pulse while requester 1 becomes valid.
        mode = 4;
        clr_force = 1'b1;
        cycles(1);
        clr_force = 1'b0;
        mode = 2;
        cycles(38);

        // Clear held high across a whole sweep.
        clr_force = 1'b1;
        cycles(20);
        clr_force = 1'b0;
        cycles(20);

        // Random traffic with sporadic clears.
        mode = 0;
        cycles(500);

        // Reset while the sweep is writing address 17.
        mode = 2;
        clr_force = 1'b1;
        cycles(1);
        clr_force = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_i);
            if (rf_wr_en_o && clear_busy_o && rf_addr_o == AW'(17)) found = 1'b1;
        end
        chk("wait_sweep_addr17", 64'(found), 64'(1));
        #2 reset_ni = 1'b0;
        #1;
        chk("async_rst_wr_en", 64'(rf_wr_en_o), 64'(0));
        chk("async_rst_addr", 64'(rf_addr_o), 64'(0));
        chk("async_rst_busy", 64'(clear_busy_o), 64'(1));
        cycles(2);
        reset_ni = 1'b1;
        mode = 0;
        cycles(200);

        // Reset at a random point of random traffic.
        #($urandom_range(1, 7));
        reset_ni = 1'b0;
        cycles(2);
        reset_ni = 1'b1;
        cycles(300);

        // Drain.
        mode = 2;
        cycles(80);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write-back requesters, legal range 2..8.
REQ-002 SHALL have parameter REG_COUNT, default 32: register count of the target register file.
REQ-003 SHALL have parameter REG_WIDTH, default 32: register data width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_ni, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port clear_req_i, input, 1: request to zero all registers via a sweep.
REQ-008 SHALL have port clear_busy_o, output, 1: high while the sweep is in progress.
REQ-009 SHALL have port req_valid_i, input, NUM_REQ: per-requester write request.
REQ-010 SHALL have port req_ready_o, output, NUM_REQ: per-requester grant, at most one bit high.
REQ-011 SHALL have port req_addr_i, input, NUM_REQ*$clog2(REG_COUNT): packed destination addresses, requester k in slice k.
REQ-012 SHALL have port req_data_i, input, NUM_REQ*REG_WIDTH: packed write data, requester k in slice k.
REQ-013 SHALL have port rf_addr_o, output, $clog2(REG_COUNT): register-file write address.
REQ-014 SHALL have port rf_data_o, output, REG_WIDTH: register-file write data.
REQ-015 SHALL have port rf_wr_en_o, output, 1: register-file write enable.
REQ-016 SHALL have port grant_id_o, output, $clog2(NUM_REQ): index of the requester whose write is currently on rf_*.

Function
REQ-017 SHALL implement an FSM with two states, CLEAR and RUN; reset enters CLEAR.
REQ-018 In CLEAR, SHALL write zero to addresses 0..REG_COUNT-1, one per cycle, in ascending order, with rf_wr_en_o=1, then enter RUN the cycle after address REG_COUNT-1 is written.
REQ-019 In CLEAR, SHALL hold req_ready_o at all-zero and clear_busy_o at 1.
REQ-020 In RUN, SHALL assert exactly one req_ready_o bit in any cycle where at least one req_valid_i bit is high, chosen round-robin; req_ready_o is combinational from req_valid_i and the priority pointer.
REQ-021 Round-robin SHALL search from the pointer upward modulo NUM_REQ; after a transfer from requester k, the pointer SHALL become (k+1) mod NUM_REQ; with no transfer it SHALL hold.
REQ-022 A transfer SHALL be req_valid_i[k] & req_ready_o[k]; rf_addr_o, rf_data_o, grant_id_o and rf_wr_en_o=1 SHALL appear registered exactly one cycle later.
REQ-023 rf_wr_en_o SHALL be 0 in any RUN cycle that follows a cycle with no transfer; rf_addr_o, rf_data_o and grant_id_o then hold their previous values.
REQ-024 Requesters hold valid, addr and data stable until ready; the block SHALL NOT buffer more than the one registered write.
REQ-025 clear_req_i sampled high in RUN SHALL move the FSM to CLEAR on the next edge, restarting the sweep at address 0; no transfer SHALL be granted in the cycle clear_req_i is high.
REQ-026 clear_req_i SHALL be ignored in CLEAR; the sweep SHALL NOT restart.
REQ-027 The sweep address counter SHALL be $clog2(REG_COUNT) bits wide and SHALL NOT wrap past REG_COUNT-1 when REG_COUNT is not a power of two.

Reset
REQ-028 On reset_ni low, the block SHALL asynchronously reset to: state CLEAR, sweep address 0, pointer 0, rf_wr_en_o=0, rf_addr_o=0, rf_data_o=0, grant_id_o=0, clear_busy_o=1, req_ready_o=0.
REQ-029 Reset asserted mid-sweep or mid-transfer SHALL abort the operation; after release, the sweep SHALL restart from address 0 on the first rising edge.

Structure
REQ-030 A shared package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the default REG_COUNT and REG_WIDTH constants.
REQ-031 Round-robin selection SHALL live in a sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, grant index).

Verification
REQ-032 Reset release with REG_COUNT=32 -> rf_wr_en_o=1 for 32 cycles with addresses 0..31 and data 0, then clear_busy_o=0.
REQ-033 RUN, all four valid held continuously -> grants 0,1,2,3,0 on consecutive cycles; each rf write appears one cycle after its grant.
REQ-034 RUN, only requester 2 valid with addr 5 and data 0xDEADBEEF -> req_ready_o=0100 in the same cycle; next cycle rf_addr_o=5, rf_data_o=0xDEADBEEF, grant_id_o=2.
REQ-035 clear_req_i pulsed during RUN while requester 1 is valid -> no grant that cycle; 32-cycle sweep runs; requester 1 is granted on the first RUN cycle.
REQ-036 reset_ni low at sweep address 17 -> outputs go to reset values immediately; after release, the sweep restarts at address 0.
REQ-037 clear_req_i held high during CLEAR -> the sweep completes 0..31 once without restarting.
